// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: one full-subtractor cell plus a borrow flop,
// producing one difference bit per clock behind valid/ready handshakes on both sides.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             brw_next;
    logic             d;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs; acc collects bits privately so the
    // visible result only changes when an operation completes.
    assign d        = a_sr[0] ^ b_sr[0] ^ brw;
    assign brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
    assign acc_next = {d, acc[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)  state_next = RUN;
            RUN:  if (last_bit)  state_next = HOLD;
            HOLD: if (out_ready) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            acc        <= '0;
            cnt        <= '0;
            brw        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr <= a;
                        b_sr <= b;
                        acc  <= '0;
                        cnt  <= '0;
                        brw  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    acc  <= acc_next;
                    brw  <= brw_next;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        diff       <= acc_next;
                        borrow_out <= brw_next;
                        zero       <= (acc_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: 8-bit and 16-bit instances share clock and reset;
// expected results are queued on acceptance and checked when each result is handed off.
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, borrow8, zero8, busy8;
    logic [7:0]  a8, b8, diff8;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, borrow16, zero16, busy16;
    logic [15:0] a16, b16, diff16;

    logic [33:0] sb8[$];
    logic [33:0] sb16[$];
    logic [33:0] e8, e16;
    int          total = 0;
    int          bad = 0;
    bit          stall_en = 0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .borrow_out(borrow8), .zero(zero8), .busy(busy8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .diff(diff16), .borrow_out(borrow16), .zero(zero16), .busy(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {zero, borrow, diff} from plain integer arithmetic.
    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] mask;
        logic [31:0] dv;
        logic        br;
        mask = (32'd1 << w) - 32'd1;
        dv   = (av - bv) & mask;
        br   = ((av & mask) < (bv & mask));
        return {(dv == 32'd0), br, dv};
    endfunction

    task automatic applyStimulus(input int w, input logic [31:0] av, input logic [31:0] bv, output int n);
        logic rdy;
        bit   accepted;
        accepted = 0;
        n = 0;
        if (w == 8) begin a8 = av[7:0]; b8 = bv[7:0]; in_valid8 = 1'b1; end
        else begin a16 = av[15:0]; b16 = bv[15:0]; in_valid16 = 1'b1; end
        while (!accepted && n < 300) begin
            rdy = (w == 8) ? in_ready8 : in_ready16;
            @(posedge clk); #1;
            n++;
            if (rdy && rst_n) accepted = 1;
        end
        if (accepted) begin
            if (w == 8) sb8.push_back(model(8, av, bv));
            else sb16.push_back(model(16, av, bv));
        end else begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
        if (w == 8) begin in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
        else begin in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); end
    endtask

    task automatic waitDrain(input int w);
        int n;
        n = 0;
        while (((w == 8) ? sb8.size() : sb16.size()) != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain", (w == 8) ? sb8.size() : sb16.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (sb8.size() == 0) begin
                checkOutput("spurious8", 32'd1, 32'd0);
            end else begin
                e8 = sb8.pop_front();
                checkOutput("diff8", 32'(diff8), e8[31:0]);
                checkOutput("borrow8", 32'(borrow8), 32'(e8[32]));
                checkOutput("zero8", 32'(zero8), 32'(e8[33]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid16 && out_ready16) begin
            if (sb16.size() == 0) begin
                checkOutput("spurious16", 32'd1, 32'd0);
            end else begin
                e16 = sb16.pop_front();
                checkOutput("diff16", 32'(diff16), e16[31:0]);
                checkOutput("borrow16", 32'(borrow16), 32'(e16[32]));
                checkOutput("zero16", 32'(zero16), 32'(e16[33]));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_en) begin
                out_ready8  = 1'($urandom_range(0, 1));
                out_ready16 = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        int n;
        int lat;
        bit seen;
        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b1;
        #12;
        checkOutput("rst_in_ready", 32'(in_ready8), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid8), 32'd0);
        checkOutput("rst_busy", 32'(busy8), 32'd0);
        checkOutput("rst_diff", 32'(diff8), 32'd0);
        checkOutput("rst_borrow", 32'(borrow8), 32'd0);
        checkOutput("rst_zero", 32'(zero8), 32'd0);
        checkOutput("rst_diff16", 32'(diff16), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] latency and handshake");
        applyStimulus(8, 32'd25, 32'd10, n);
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            checkOutput("run_in_ready", 32'(in_ready8), 32'd0);
            checkOutput("run_busy", 32'(busy8), 32'd1);
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'd8);
        checkOutput("hold_in_ready", 32'(in_ready8), 32'd0);
        checkOutput("hold_busy", 32'(busy8), 32'd0);
        @(posedge clk); #1;
        checkOutput("idle_in_ready", 32'(in_ready8), 32'd1);
        checkOutput("idle_out_valid", 32'(out_valid8), 32'd0);

        $display("[TB] directed values");
        applyStimulus(8, 32'd10, 32'd25, n);
        applyStimulus(8, 32'hAA, 32'hAA, n);
        applyStimulus(8, 32'h00, 32'h01, n);
        applyStimulus(8, 32'hFF, 32'h00, n);
        applyStimulus(16, 32'h0000, 32'h0001, n);
        applyStimulus(16, 32'hFFFF, 32'hFFFF, n);

        $display("[TB] backpressure");
        applyStimulus(8, 32'h80, 32'h7F, n);
        out_ready8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 50) begin @(posedge clk); #1; n++; end
        checkOutput("bp_reach_hold", 32'(out_valid8), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid8 = ~in_valid8;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(posedge clk); #1;
            checkOutput("bp_out_valid", 32'(out_valid8), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready8), 32'd0);
            checkOutput("bp_diff", 32'(diff8), 32'h01);
            checkOutput("bp_borrow", 32'(borrow8), 32'd0);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        applyStimulus(8, 32'h33, 32'h11, n);
        checkOutput("bp_accept_edges", 32'(n), 32'd2);
        waitDrain(8);

        $display("[TB] reset mid-operation");
        applyStimulus(8, 32'h5A, 32'h13, n);
        repeat (4) @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", 32'(in_ready8), 32'd1);
        checkOutput("mid_rst_busy", 32'(busy8), 32'd0);
        checkOutput("mid_rst_out_valid", 32'(out_valid8), 32'd0);
        checkOutput("mid_rst_diff", 32'(diff8), 32'd0);
        sb8.delete();
        #7 rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid8) seen = 1;
        end
        checkOutput("no_result_after_reset", 32'(seen), 32'd0);
        applyStimulus(8, 32'h5A, 32'h13, n);
        waitDrain(8);

        $display("[TB] random with stalls");
        stall_en = 1;
        for (int i = 0; i < 1000; i++) applyStimulus(8, $urandom, $urandom, n);
        waitDrain(8);
        for (int i = 0; i < 1000; i++) applyStimulus(16, $urandom, $urandom, n);
        waitDrain(16);
        stall_en = 0;
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        out_ready16 = 1'b1;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
